instr_fetch: RTL and testbench

Instruction-fetch initiator for the 8-bit core. It drives the read address of the combinational instruction memory and owns the program counter. Each fetched instruction is captured with its PC into a small fetch queue, and the head entry is presented to decode over a valid/ready handshake. Execute can redirect the PC for jumps and branches, which flushes the queue.

---
 rtl/core_pkg.sv | 48 ++++
 rtl/instr_fetch_fetch_queue.sv | 59 +++++
 rtl/instr_fetch.sv | 92 +++++++++
 tb/tb_instr_fetch.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the 8-bit core: widths, instruction field slices,
// opcodes, the fetch-queue entry layout and the fetch FSM state type.
package core_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 8;

  localparam int OP_MSB = 7;
  localparam int OP_LSB = 6;
  localparam int RS_MSB = 5;
  localparam int RS_LSB = 4;
  localparam int RT_MSB = 3;
  localparam int RT_LSB = 2;
  localparam int RD_MSB = 1;
  localparam int RD_LSB = 0;

  localparam logic [1:0] OP_ALU    = 2'b00;
  localparam logic [1:0] OP_LOAD   = 2'b01;
  localparam logic [1:0] OP_STORE  = 2'b10;
  localparam logic [1:0] OP_BRANCH = 2'b11;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    FS_IDLE  = 1'b0,
    FS_FETCH = 1'b1
  } fetch_state_t;

  function automatic logic [1:0] instr_op(input logic [INSTR_W-1:0] instr);
    return instr[OP_MSB:OP_LSB];
  endfunction

  function automatic logic [1:0] instr_rs(input logic [INSTR_W-1:0] instr);
    return instr[RS_MSB:RS_LSB];
  endfunction

  function automatic logic [1:0] instr_rt(input logic [INSTR_W-1:0] instr);
    return instr[RT_MSB:RT_LSB];
  endfunction

  function automatic logic [1:0] instr_rd(input logic [INSTR_W-1:0] instr);
    return instr[RD_MSB:RD_LSB];
  endfunction

endpackage

// File: rtl/instr_fetch_fetch_queue.sv
// DEPTH-entry synchronous FIFO holding fetched {pc, instr} entries; the head
// is presented straight from registered storage.
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_head,
  output logic                     o_valid,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Flush wins over push and pop; storage is not cleared since count gates validity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_valid = (r_count != '0);
  assign o_count = r_count;

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch initiator: owns the PC, drives the instruction-memory
// address, queues fetched instructions and handles execute redirects.
module instr_fetch #(
  parameter int ADDR_W                = core_pkg::ADDR_W,
  parameter int INSTR_W               = core_pkg::INSTR_W,
  parameter int DEPTH                 = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fetch_en,
  output logic [ADDR_W-1:0]        Read_Address,
  input  logic [INSTR_W-1:0]       instruction,
  input  logic                     redirect_valid,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [INSTR_W-1:0]       out_instr,
  output logic [ADDR_W-1:0]        out_pc,
  output logic [$clog2(DEPTH):0]   q_count
);

  import core_pkg::*;

  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = ADDR_W + INSTR_W;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  fetch_state_t       r_state;
  fetch_state_t       w_next_state;
  logic [ADDR_W-1:0]  r_pc;
  logic               w_fetching;
  logic               w_full;
  logic               w_pop;
  logic               w_push;
  logic               w_valid;
  logic [ENTRY_W-1:0] w_head;
  logic [CNT_W-1:0]   w_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FS_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = fetch_en ? FS_FETCH : FS_IDLE;
  end

  always_comb begin
    w_fetching = (r_state == FS_FETCH);
  end

  // A full queue can still accept a push when the head leaves on the same edge.
  assign w_full = (w_count == FULL_COUNT);
  assign w_pop  = w_valid & out_ready;
  assign w_push = w_fetching & fetch_en & ~redirect_valid & (~w_full | w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc <= redirect_pc;
    end else if (w_push) begin
      r_pc <= r_pc + ADDR_W'(1);
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fetch_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .i_data  ({r_pc, instruction}),
    .o_head  (w_head),
    .o_valid (w_valid),
    .o_count (w_count)
  );

  assign Read_Address = r_pc;
  assign out_valid    = w_valid;
  assign out_pc       = w_head[ENTRY_W-1:INSTR_W];
  assign out_instr    = w_head[INSTR_W-1:0];
  assign q_count      = w_count;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios with fixed
// expectations plus randomized traffic against a queue-based reference model.
module tb_instr_fetch;

  localparam int DEPTH = 2;

  logic       clk;
  logic       rst_n;
  logic       fetch_en;
  logic [7:0] Read_Address;
  logic [7:0] instruction;
  logic       redirect_valid;
  logic [7:0] redirect_pc;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_instr;
  logic [7:0] out_pc;
  logic [1:0] q_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] pc;
    logic [7:0] instr;
  } entry_t;

  entry_t     mQ[$];
  logic [7:0] mPc;
  bit         mFetch;

  logic [7:0] expStreamInstr [4] = '{8'h49, 8'hC1, 8'h18, 8'hA9};
  logic [7:0] expWrapPc      [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
  logic [7:0] expWrapInstr   [4] = '{8'h00, 8'h00, 8'h49, 8'hC1};

  function automatic logic [7:0] imem(input logic [7:0] addr);
    case (addr)
      8'h00:   return 8'h49;
      8'h01:   return 8'hC1;
      8'h02:   return 8'h18;
      8'h03:   return 8'hA9;
      8'h04:   return 8'h4D;
      default: return 8'h00;
    endcase
  endfunction

  assign instruction = imem(Read_Address);

  instr_fetch #(
    .ADDR_W   (8),
    .INSTR_W  (8),
    .DEPTH    (DEPTH),
    .RESET_PC (8'h00)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .Read_Address   (Read_Address),
    .instruction    (instruction),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .q_count        (q_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: advances one clock edge using the inputs held across it.
  task automatic model_step();
    bit     pop;
    bit     push;
    entry_t e;
    pop  = (mQ.size() > 0) && out_ready;
    push = mFetch && fetch_en && !redirect_valid && ((mQ.size() < DEPTH) || pop);
    if (redirect_valid) begin
      mQ.delete();
      mPc = redirect_pc;
    end else begin
      if (pop) void'(mQ.pop_front());
      if (push) begin
        e.pc    = mPc;
        e.instr = imem(mPc);
        mQ.push_back(e);
        mPc = mPc + 8'd1;
      end
    end
    mFetch = fetch_en;
  endtask

  task automatic model_reset();
    mQ.delete();
    mPc    = 8'h00;
    mFetch = 1'b0;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    fetch_en       = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%0b exp=0", out_valid); end
    total++; if (Read_Address !== 8'h00) begin bad++; $display("[TB] FAIL reset_addr got=%h exp=00", Read_Address); end
    total++; if (q_count !== 2'd0) begin bad++; $display("[TB] FAIL reset_count got=%0d exp=0", q_count); end
    total++; if (out_pc !== 8'h00 || out_instr !== 8'h00) begin bad++; $display("[TB] FAIL reset_head got=(%h,%h) exp=(00,00)", out_pc, out_instr); end
  endtask

  task automatic test_stream();
    do_reset();
    fetch_en  = 1'b1;
    out_ready = 1'b1;
    cycle();
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL stream_first_bubble got=%0b exp=0", out_valid); end
    for (int k = 0; k < 4; k++) begin
      cycle();
      total++;
      if (out_valid !== 1'b1 || out_pc !== 8'(k) || out_instr !== expStreamInstr[k]) begin
        bad++;
        $display("[TB] FAIL stream_%0d got=(v%0b,%h,%h) exp=(v1,%h,%h)", k, out_valid, out_pc, out_instr, 8'(k), expStreamInstr[k]);
      end
      total++;
      if (Read_Address !== 8'(k + 1) || q_count !== 2'd1) begin
        bad++;
        $display("[TB] FAIL stream_addr_%0d got=(%h,%0d) exp=(%h,1)", k, Read_Address, q_count, 8'(k + 1));
      end
    end
  endtask

  task automatic test_saturate();
    do_reset();
    fetch_en  = 1'b1;
    out_ready = 1'b0;
    cycle();
    for (int k = 0; k < 5; k++) cycle();
    total++; if (q_count !== 2'd2 || Read_Address !== 8'h02) begin bad++; $display("[TB] FAIL sat_full got=(%0d,%h) exp=(2,02)", q_count, Read_Address); end
    total++; if (out_valid !== 1'b1 || out_pc !== 8'h00 || out_instr !== 8'h49) begin bad++; $display("[TB] FAIL sat_head got=(%h,%h) exp=(00,49)", out_pc, out_instr); end
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    total++; if (q_count !== 2'd2 || Read_Address !== 8'h03) begin bad++; $display("[TB] FAIL sat_pushpop got=(%0d,%h) exp=(2,03)", q_count, Read_Address); end
    total++; if (out_pc !== 8'h01 || out_instr !== 8'hC1) begin bad++; $display("[TB] FAIL sat_head2 got=(%h,%h) exp=(01,C1)", out_pc, out_instr); end
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    total++; if (out_pc !== 8'h02 || out_instr !== 8'h18 || q_count !== 2'd2) begin bad++; $display("[TB] FAIL sat_tail got=(%h,%h,%0d) exp=(02,18,2)", out_pc, out_instr, q_count); end
    fetch_en  = 1'b0;
    out_ready = 1'b1;
    cycle();
    total++; if (out_pc !== 8'h03 || out_instr !== 8'hA9 || q_count !== 2'd1) begin bad++; $display("[TB] FAIL sat_drain1 got=(%h,%h,%0d) exp=(03,A9,1)", out_pc, out_instr, q_count); end
    cycle();
    total++; if (out_valid !== 1'b0 || q_count !== 2'd0 || Read_Address !== 8'h04) begin bad++; $display("[TB] FAIL sat_empty got=(v%0b,%0d,%h) exp=(v0,0,04)", out_valid, q_count, Read_Address); end
  endtask

  task automatic test_redirect();
    do_reset();
    fetch_en  = 1'b1;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) cycle();
    total++; if (q_count !== 2'd2) begin bad++; $display("[TB] FAIL redir_prefill got=%0d exp=2", q_count); end
    redirect_valid = 1'b1;
    redirect_pc    = 8'h04;
    out_ready      = 1'b1;
    cycle();
    redirect_valid = 1'b0;
    total++; if (out_valid !== 1'b0 || Read_Address !== 8'h04 || q_count !== 2'd0) begin bad++; $display("[TB] FAIL redir_flush got=(v%0b,%h,%0d) exp=(v0,04,0)", out_valid, Read_Address, q_count); end
    cycle();
    total++; if (out_valid !== 1'b1 || out_pc !== 8'h04 || out_instr !== 8'h4D) begin bad++; $display("[TB] FAIL redir_first got=(v%0b,%h,%h) exp=(v1,04,4D)", out_valid, out_pc, out_instr); end
    cycle();
    total++; if (out_pc !== 8'h05 || out_instr !== 8'h00 || Read_Address !== 8'h06) begin bad++; $display("[TB] FAIL redir_second got=(%h,%h,%h) exp=(05,00,06)", out_pc, out_instr, Read_Address); end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1;
    redirect_pc    = 8'hFE;
    cycle();
    redirect_valid = 1'b0;
    total++; if (out_valid !== 1'b0 || Read_Address !== 8'hFE) begin bad++; $display("[TB] FAIL wrap_flush got=(v%0b,%h) exp=(v0,FE)", out_valid, Read_Address); end
    for (int k = 0; k < 4; k++) begin
      cycle();
      total++;
      if (out_valid !== 1'b1 || out_pc !== expWrapPc[k] || out_instr !== expWrapInstr[k]) begin
        bad++;
        $display("[TB] FAIL wrap_%0d got=(v%0b,%h,%h) exp=(v1,%h,%h)", k, out_valid, out_pc, out_instr, expWrapPc[k], expWrapInstr[k]);
      end
    end
  endtask

  task automatic test_redirect_idle();
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 8'h03;
    cycle();
    redirect_valid = 1'b0;
    total++; if (Read_Address !== 8'h03 || q_count !== 2'd0) begin bad++; $display("[TB] FAIL idle_redir got=(%h,%0d) exp=(03,0)", Read_Address, q_count); end
    fetch_en  = 1'b1;
    out_ready = 1'b1;
    cycle();
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL idle_bubble got=%0b exp=0", out_valid); end
    cycle();
    total++; if (out_valid !== 1'b1 || out_pc !== 8'h03 || out_instr !== 8'hA9) begin bad++; $display("[TB] FAIL idle_first got=(v%0b,%h,%h) exp=(v1,03,A9)", out_valid, out_pc, out_instr); end
  endtask

  task automatic test_async_reset();
    fetch_en  = 1'b1;
    out_ready = 1'b1;
    cycle();
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_pc !== 8'h00 || out_instr !== 8'h00 || Read_Address !== 8'h00 || q_count !== 2'd0) begin
      bad++;
      $display("[TB] FAIL async_reset got=(v%0b,%h,%h,%h,%0d) exp=(v0,00,00,00,0)", out_valid, out_pc, out_instr, Read_Address, q_count);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    cycle();
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL async_bubble got=%0b exp=0", out_valid); end
    cycle();
    total++; if (out_valid !== 1'b1 || out_pc !== 8'h00 || out_instr !== 8'h49) begin bad++; $display("[TB] FAIL async_resume got=(v%0b,%h,%h) exp=(v1,00,49)", out_valid, out_pc, out_instr); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      fetch_en       = ($urandom_range(0, 9) != 0);
      out_ready      = $urandom_range(0, 1);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom_range(0, 1) ? 8'($urandom_range(0, 6)) : 8'($urandom_range(250, 255));
      cycle();
      total++;
      if (out_valid !== (mQ.size() > 0) || q_count !== 2'(mQ.size()) || Read_Address !== mPc) begin
        bad++;
        $display("[TB] FAIL rand_state_%0d got=(v%0b,%0d,%h) exp=(v%0b,%0d,%h)", n, out_valid, q_count, Read_Address, mQ.size() > 0, mQ.size(), mPc);
      end
      if (mQ.size() > 0) begin
        total++;
        if (out_pc !== mQ[0].pc || out_instr !== mQ[0].instr) begin
          bad++;
          $display("[TB] FAIL rand_head_%0d got=(%h,%h) exp=(%h,%h)", n, out_pc, out_instr, mQ[0].pc, mQ[0].instr);
        end
      end
    end
    redirect_valid = 1'b0;
  endtask

  initial begin
    rst_n          = 1'b0;
    fetch_en       = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
    model_reset();
    #2;
    test_reset();
    test_stream();
    test_saturate();
    test_redirect();
    test_wrap();
    test_redirect_idle();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout got=running exp=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
